// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster generator with registered, mutually aligned x/y/active/hsync/vsync.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
`default_nettype none

/*============================================================================
 * Module   : vga_timing_gen
 * Brief    : Pixel/line counters plus sync, active and start-of-line/frame
 *            strobes, all registered from the next counter values.
 * Option   : VGA_FRAME_COUNT_EN adds an 8-bit wrapping frame_count output.
 * Revision : 1.0 - initial release
 *============================================================================*/
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive bounds keep every constant representable in 10 bits even at a total of 1024.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_width_check
        $error("vga_timing_gen: active and sync widths must be at least 1");
    end

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
        // Flags are derived from the position being entered, so they line up with x/y.
        active_d      = (x_d <= H_ACT_LAST) && (y_d <= V_ACT_LAST);
        hsync_d       = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = (x_d == '0);
        frame_start_d = (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end else begin
            // Strobes last one clk even when pix_en is held low between pixels.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
        end else if (pix_en && frame_start_d) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance checked from a vector table, plus a
// small-timing instance checked every clk against a position-arithmetic model.
`default_nettype none

/*============================================================================
 * Module   : tb_vga_timing_gen
 * Brief    : Self-checking bench for vga_timing_gen (honours VGA_FRAME_COUNT_EN).
 * Revision : 1.0 - initial release
 *============================================================================*/
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
    localparam int F  = HT * VT;
    localparam bit SP = 1'b1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       a;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int   tick;
        obs_t exp;
    } dvec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // default-timing instance
    logic       d_rst_n, d_en;
    logic [9:0] d_x, d_y;
    logic       d_a, d_hs, d_vs, d_ls, d_fs;

    vga_timing_gen u_dut_default (
        .clk        (clk),
        .rst_n      (d_rst_n),
        .pix_en     (d_en),
        .x          (d_x),
        .y          (d_y),
        .active     (d_a),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .line_start (d_ls),
        .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count()
`endif
    );

    // small-timing instance, active-high syncs
    logic       s_rst_n, s_en;
    logic [9:0] s_x, s_y;
    logic       s_a, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] s_fc;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SP)
    ) u_dut_small (
        .clk        (clk),
        .rst_n      (s_rst_n),
        .pix_en     (s_en),
        .x          (s_x),
        .y          (s_y),
        .active     (s_a),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .line_start (s_ls),
        .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(s_fc)
`endif
    );
`ifndef VGA_FRAME_COUNT_EN
    assign s_fc = 8'd0;
`endif

    function automatic obs_t mk(int xx, int yy, bit a, bit hs, bit vs, bit ls, bit fs);
        obs_t o;
        o.x = 10'(xx); o.y = 10'(yy); o.a = a; o.hs = hs; o.vs = vs;
        o.ls = ls; o.fs = fs; o.fc = 8'd0;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                         o.x, o.y, o.a, o.hs, o.vs, o.ls, o.fs, o.fc);
    endfunction

    task automatic cmp(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic obs_t d_obs();
        return mk(d_x, d_y, d_a, d_hs, d_vs, d_ls, d_fs);
    endfunction

    function automatic obs_t s_obs();
        obs_t o;
        o = mk(s_x, s_y, s_a, s_hs, s_vs, s_ls, s_fs);
        o.fc = s_fc;
        return o;
    endfunction

    // Reference: n pixel ticks since reset release give raster position (n-1) mod F.
    function automatic obs_t s_model(int n, bit ticked);
        obs_t o;
        int p, xx, yy;
        if (n == 0) begin
            o = mk(HT - 1, VT - 1, 1'b0, ~SP, ~SP, 1'b0, 1'b0);
        end else begin
            p  = (n - 1) % F;
            xx = p % HT;
            yy = p / HT;
            o = mk(xx, yy, (xx < HA) && (yy < VA),
                   (xx >= HA + HF && xx < HA + HF + HS) ? SP : ~SP,
                   (yy >= VA + VF && yy < VA + VF + VS) ? SP : ~SP,
                   ticked && (xx == 0), ticked && (p == 0));
`ifdef VGA_FRAME_COUNT_EN
            o.fc = 8'(((n - 1) / F + 1) % 256);
`endif
        end
        return o;
    endfunction

    int sn   = 0;
    bit s_tk = 1'b0;
    int cyc  = 0;

    task automatic s_step(input bit en);
        s_en = en;
        @(posedge clk);
        #1;
        cyc++;
        if (!s_rst_n) begin
            sn = 0; s_tk = 1'b0;
        end else if (en) begin
            sn++; s_tk = 1'b1;
        end else begin
            s_tk = 1'b0;
        end
        cmp("small_model", s_obs(), s_model(sn, s_tk));
    endtask

    int dt     = 0;
    int hs_low = 0;

    task automatic d_tick();
        @(posedge clk);
        #1;
        dt++;
        if (dt <= 800 && d_hs == 1'b0) hs_low++;
    endtask

    dvec_t dtab[11];

    initial begin
        int fs_cyc[$];
        int vs_cnt, blank_act, wide;
        bit prev, found;

        d_rst_n = 1'b0; d_en = 1'b1;
        s_rst_n = 1'b0; s_en = 1'b0;

        dtab[0]  = '{0,   mk(799, 524, 0, 1, 1, 0, 0)};
        dtab[1]  = '{1,   mk(0,   0,   1, 1, 1, 1, 1)};
        dtab[2]  = '{2,   mk(1,   0,   1, 1, 1, 0, 0)};
        dtab[3]  = '{640, mk(639, 0,   1, 1, 1, 0, 0)};
        dtab[4]  = '{641, mk(640, 0,   0, 1, 1, 0, 0)};
        dtab[5]  = '{656, mk(655, 0,   0, 1, 1, 0, 0)};
        dtab[6]  = '{657, mk(656, 0,   0, 0, 1, 0, 0)};
        dtab[7]  = '{752, mk(751, 0,   0, 0, 1, 0, 0)};
        dtab[8]  = '{753, mk(752, 0,   0, 1, 1, 0, 0)};
        dtab[9]  = '{800, mk(799, 0,   0, 1, 1, 0, 0)};
        dtab[10] = '{801, mk(0,   1,   1, 1, 1, 1, 0)};

        repeat (2) @(posedge clk);
        #1;
        cmp("small_reset", s_obs(), s_model(0, 1'b0));
        d_rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            while (dt < dtab[i].tick) d_tick();
            cmp($sformatf("default_tick%0d", dtab[i].tick), d_obs(), dtab[i].exp);
        end
        chk_int("hsync_low_pixels", hs_low, 96);
        d_en = 1'b0;
        d_tick();
        cmp("default_hold", d_obs(), mk(0, 1, 1, 1, 1, 0, 0));
        d_en = 1'b1;

        // two full frames, continuous pix_en
        s_rst_n = 1'b1;
        vs_cnt = 0; blank_act = 0;
        for (int k = 1; k <= 2 * F + 1; k++) begin
            s_step(1'b1);
            if (s_fs) fs_cyc.push_back(cyc);
            if (k <= F && s_vs == SP) vs_cnt++;
            if (s_a && s_y >= VA) blank_act++;
        end
        chk_int("frame_pulses", fs_cyc.size(), 3);
        if (fs_cyc.size() >= 2) chk_int("frame_period", fs_cyc[1] - fs_cyc[0], F);
        chk_int("vsync_ticks", vs_cnt, VS * HT);
        chk_int("active_in_vblank", blank_act, 0);

        // pix_en every other clk
        fs_cyc.delete();
        prev = 1'b0; wide = 0;
        for (int k = 0; k < 4 * F + 8; k++) begin
            s_step(k % 2 == 0);
            if (s_fs && !prev) fs_cyc.push_back(cyc);
            if (s_fs && prev) wide++;
            prev = s_fs;
        end
        chk_int("alt_two_pulses", fs_cyc.size() >= 2, 1);
        if (fs_cyc.size() >= 2) chk_int("alt_frame_period", fs_cyc[1] - fs_cyc[0], 2 * F);
        chk_int("alt_pulse_wide", wide, 0);

        // asynchronous reset mid-frame
        found = (s_y == 3 && s_x == 5);
        for (int k = 0; k < 2 * F && !found; k++) begin
            s_step(1'b1);
            found = (s_y == 3 && s_x == 5);
        end
        chk_int("seek_y3_x5", found, 1);
        #2;
        s_rst_n = 1'b0;
        #1;
        cmp("async_reset", s_obs(), s_model(0, 1'b0));
        s_step(1'b1);
        s_step(1'b1);
        s_rst_n = 1'b1;
        s_step(1'b1);
        chk_int("after_reset_origin", (s_x == 0) && (s_y == 0) && s_fs && s_ls, 1);

        // randomized pix_en against the model
        for (int k = 0; k < 3000; k++) begin
            s_step(1'($urandom_range(0, 1)));
        end

`ifdef VGA_FRAME_COUNT_EN
        s_rst_n = 1'b0;
        s_step(1'b0);
        s_rst_n = 1'b1;
        chk_int("fc_reset", s_fc, 0);
        while (sn < 255 * F + 1) begin
            s_step(1'b1);
            if (sn == 1)           chk_int("fc_frame1", s_fc, 1);
            if (sn == 254 * F + 1) chk_int("fc_frame255", s_fc, 255);
            if (sn == 255 * F + 1) chk_int("fc_frame256", s_fc, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
